// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
// Op decoding and store lane replication live here so the top and the bench agree.
package mem_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LW  = 4'd5,
        SB  = 4'd6,
        SH  = 4'd7,
        SW  = 4'd8,
        LL  = 4'd9,
        SC  = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } mem_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) ||
               (op == LW) || (op == LL);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW) || (op == SC);
    endfunction

    function automatic logic [1:0] op_size(input mem_op_t op);
        case (op)
            LB, LBU, SB: return SZ_BYTE;
            LH, LHU, SH: return SZ_HALF;
            LW, SW, LL, SC: return SZ_WORD;
            default: return SZ_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] addr);
        case (op_size(op))
            SZ_HALF: return addr[0];
            SZ_WORD: return (addr != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input mem_op_t op, input logic [31:0] wdata);
        case (op)
            SB: return {4{wdata[7:0]}};
            SH: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data bus between the MEM-stage access unit (master) and the memory system (slave).
interface mem_access_unit_if;

    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

endinterface

// File: rtl/mem_load_align.sv
// Load formatting: picks the byte/half lane from the raw bus word and extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] raw,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = raw[7:0];
            2'd1:    w_byte = raw[15:8];
            2'd2:    w_byte = raw[23:16];
            default: w_byte = raw[31:24];
        endcase
        w_half = addr[1] ? raw[31:16] : raw[15:0];

        case (op)
            LB:      rdata = {{24{w_byte[7]}}, w_byte};
            LBU:     rdata = {24'd0, w_byte};
            LH:      rdata = {{16{w_half[15]}}, w_half};
            LHU:     rdata = {16'd0, w_half};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: loads, stores, LL/SC over a req/addr_ok/data_ok bus.
// Stalls the pipeline while a transfer is outstanding and drains bus responses after a flush.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_valid_i,
    input  mem_op_t     mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        LLbit_i,
    output logic        LLbit_o,
    output logic        LLbit_we_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        addr_err_o,
    output logic        stall_o,
    mem_access_unit_if.master bus
);

    mem_state_t  r_state;
    mem_op_t     r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_misal;
    logic        w_sc_fail;
    logic        w_start;
    logic        w_bus_done;
    logic [31:0] w_load_data;

    assign w_accept   = (r_state == S_IDLE) && mem_valid_i && (mem_op_i != NOP) && !flush;
    assign w_misal    = misaligned(mem_op_i, addr_i[1:0]);
    assign w_sc_fail  = (mem_op_i == SC) && !LLbit_i;
    assign w_start    = w_accept && !w_misal && !w_sc_fail;
    assign w_bus_done = !flush && bus.data_data_ok_i &&
                        (((r_state == S_ADDR) && bus.data_addr_ok_i) || (r_state == S_DATA));

    mem_load_align u_align (
        .op    (r_op),
        .addr  (r_addr[1:0]),
        .raw   (bus.data_rdata_i),
        .rdata (w_load_data)
    );

    assign bus.data_req_o   = (r_state == S_ADDR);
    assign bus.data_wr_o    = is_store(r_op);
    assign bus.data_size_o  = op_size(r_op);
    assign bus.data_addr_o  = r_addr;
    assign bus.data_wdata_o = store_lanes(r_op, r_wdata);

    always_comb begin
        done_o     = (w_accept && (w_misal || w_sc_fail)) || w_bus_done;
        addr_err_o = w_accept && w_misal;
        LLbit_we_o = w_bus_done && ((r_op == LL) || (r_op == SC));
        LLbit_o    = w_bus_done && (r_op == LL);

        rdata_o = '0;
        if (w_bus_done) begin
            if (r_op == SC)
                rdata_o = 32'd1;
            else if (is_load(r_op))
                rdata_o = w_load_data;
        end

        case (r_state)
            S_IDLE:  stall_o = w_start;
            S_DRAIN: stall_o = mem_valid_i;
            default: stall_o = !w_bus_done;
        endcase
        if (flush)
            stall_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= NOP;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= mem_op_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // A flush that coincides with addr_ok+data_ok has nothing left to drain.
                    if (flush) begin
                        if (bus.data_addr_ok_i && !bus.data_data_ok_i)
                            r_state <= S_DRAIN;
                        else
                            r_state <= S_IDLE;
                    end else if (bus.data_addr_ok_i) begin
                        r_state <= bus.data_data_ok_i ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.data_data_ok_i)
                        r_state <= S_IDLE;
                    else if (flush)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (bus.data_data_ok_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single-transfer ops plus
// hand-written sequences for wait states, flush/drain and reset mid-transfer.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_valid_i;
    mem_op_t     mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        LLbit_i;
    logic        LLbit_o;
    logic        LLbit_we_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        addr_err_o;
    logic        stall_o;

    mem_access_unit_if bus_if ();

    mem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mem_valid_i (mem_valid_i),
        .mem_op_i    (mem_op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .LLbit_i     (LLbit_i),
        .LLbit_o     (LLbit_o),
        .LLbit_we_o  (LLbit_we_o),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .addr_err_o  (addr_err_o),
        .stall_o     (stall_o),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        llbit;
        logic [31:0] bus_rdata;
        logic        exp_bus;
        logic        exp_err;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_llwe;
        logic        exp_llo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drive_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                            input logic llb);
        mem_valid_i = 1'b1;
        mem_op_i    = op;
        addr_i      = a;
        wdata_i     = wd;
        LLbit_i     = llb;
    endtask

    task automatic idle_inputs;
        mem_valid_i = 1'b0;
        mem_op_i    = NOP;
        flush       = 1'b0;
        bus_if.data_addr_ok_i = 1'b0;
        bus_if.data_data_ok_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        addr_i = '0;
        wdata_i = '0;
        LLbit_i = 1'b0;
        bus_if.data_rdata_i = '0;
        idle_inputs();

        //       op   addr          wdata         llb   bus_rdata     bus   err   wr    size     exp_wdata     exp_rdata     llwe  llo
        vecs.push_back('{LB,  32'h0000_0103, 32'h0, 1'b0, 32'h8011_2233, 1'b1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0});
        vecs.push_back('{LBU, 32'h0000_0103, 32'h0, 1'b0, 32'h8011_2233, 1'b1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0000_0080, 1'b0, 1'b0});
        vecs.push_back('{LB,  32'h0000_0101, 32'h0, 1'b0, 32'h8011_2233, 1'b1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0000_0022, 1'b0, 1'b0});
        vecs.push_back('{LBU, 32'h0000_0102, 32'h0, 1'b0, 32'h00AA_0000, 1'b1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0000_00AA, 1'b0, 1'b0});
        vecs.push_back('{LH,  32'h0000_0102, 32'h0, 1'b0, 32'h8011_2233, 1'b1, 1'b0, 1'b0, SZ_HALF, 32'h0, 32'hFFFF_8011, 1'b0, 1'b0});
        vecs.push_back('{LHU, 32'h0000_0100, 32'h0, 1'b0, 32'h8011_9233, 1'b1, 1'b0, 1'b0, SZ_HALF, 32'h0, 32'h0000_9233, 1'b0, 1'b0});
        vecs.push_back('{LW,  32'h0000_0104, 32'h0, 1'b0, 32'h0123_4567, 1'b1, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0123_4567, 1'b0, 1'b0});
        vecs.push_back('{SB,  32'h0000_0101, 32'h1234_56C3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, SZ_BYTE, 32'hC3C3_C3C3, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{SH,  32'h0000_0102, 32'h1234_ABCD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, SZ_HALF, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{SW,  32'h0000_0104, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, SZ_WORD, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{LL,  32'h0000_0200, 32'h0, 1'b0, 32'h5566_7788, 1'b1, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h5566_7788, 1'b1, 1'b1});
        vecs.push_back('{SC,  32'h0000_0200, 32'h0000_0011, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, SZ_WORD, 32'h0000_0011, 32'h1, 1'b1, 1'b0});
        vecs.push_back('{SC,  32'h0000_0200, 32'h0000_0022, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{LW,  32'h0000_0102, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, SZ_BYTE, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{LH,  32'h0000_0101, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, SZ_BYTE, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{LHU, 32'h0000_0103, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, SZ_BYTE, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{SW,  32'h0000_0103, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, SZ_BYTE, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{SC,  32'h0000_0201, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, SZ_BYTE, 32'h0, 32'h0, 1'b0, 1'b0});

        // Reset state
        nxt(); nxt();
        rst = 1'b0;
        smp();
        chk1 ("rst_req",   bus_if.data_req_o, 1'b0);
        chk1 ("rst_wr",    bus_if.data_wr_o, 1'b0);
        chk32("rst_size",  {30'd0, bus_if.data_size_o}, 32'd0);
        chk32("rst_addr",  bus_if.data_addr_o, 32'd0);
        chk32("rst_wdata", bus_if.data_wdata_o, 32'd0);
        chk1 ("rst_done",  done_o, 1'b0);
        chk1 ("rst_err",   addr_err_o, 1'b0);
        chk1 ("rst_stall", stall_o, 1'b0);
        chk1 ("rst_llwe",  LLbit_we_o, 1'b0);
        chk1 ("rst_llo",   LLbit_o, 1'b0);
        chk32("rst_rdata", rdata_o, 32'd0);
        nxt();

        // Table: accept in IDLE, then either immediate completion or one-cycle bus transfer
        for (int i = 0; i < vecs.size(); i++) begin
            drive_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].llbit);
            smp();
            if (!vecs[i].exp_bus) begin
                chk1 ($sformatf("v%0d_done", i),  done_o, 1'b1);
                chk1 ($sformatf("v%0d_err", i),   addr_err_o, vecs[i].exp_err);
                chk1 ($sformatf("v%0d_req", i),   bus_if.data_req_o, 1'b0);
                chk1 ($sformatf("v%0d_stall", i), stall_o, 1'b0);
                chk32($sformatf("v%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
                chk1 ($sformatf("v%0d_llwe", i),  LLbit_we_o, 1'b0);
                nxt();
                idle_inputs();
                smp();
                chk1 ($sformatf("v%0d_noreq", i), bus_if.data_req_o, 1'b0);
                nxt();
            end else begin
                chk1 ($sformatf("v%0d_t0_done", i),  done_o, 1'b0);
                chk1 ($sformatf("v%0d_t0_stall", i), stall_o, 1'b1);
                chk1 ($sformatf("v%0d_t0_req", i),   bus_if.data_req_o, 1'b0);
                nxt();
                bus_if.data_addr_ok_i = 1'b1;
                bus_if.data_data_ok_i = 1'b1;
                bus_if.data_rdata_i   = vecs[i].bus_rdata;
                smp();
                chk1 ($sformatf("v%0d_req", i),   bus_if.data_req_o, 1'b1);
                chk1 ($sformatf("v%0d_wr", i),    bus_if.data_wr_o, vecs[i].exp_wr);
                chk32($sformatf("v%0d_size", i),  {30'd0, bus_if.data_size_o}, {30'd0, vecs[i].exp_size});
                chk32($sformatf("v%0d_addr", i),  bus_if.data_addr_o, vecs[i].addr);
                chk32($sformatf("v%0d_wdata", i), bus_if.data_wdata_o, vecs[i].exp_wdata);
                chk1 ($sformatf("v%0d_done", i),  done_o, 1'b1);
                chk1 ($sformatf("v%0d_err", i),   addr_err_o, 1'b0);
                chk32($sformatf("v%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
                chk1 ($sformatf("v%0d_llwe", i),  LLbit_we_o, vecs[i].exp_llwe);
                chk1 ($sformatf("v%0d_llo", i),   LLbit_o, vecs[i].exp_llo);
                chk1 ($sformatf("v%0d_stall", i), stall_o, 1'b0);
                nxt();
                idle_inputs();
            end
        end

        // LW with addr_ok at T1 and data_ok at T3
        drive_op(LW, 32'h0000_0100, 32'h0, 1'b0);
        smp();
        chk1("lw_t0_stall", stall_o, 1'b1);
        chk1("lw_t0_done",  done_o, 1'b0);
        nxt();
        bus_if.data_addr_ok_i = 1'b1;
        smp();
        chk1("lw_t1_req",   bus_if.data_req_o, 1'b1);
        chk1("lw_t1_stall", stall_o, 1'b1);
        chk1("lw_t1_done",  done_o, 1'b0);
        nxt();
        bus_if.data_addr_ok_i = 1'b0;
        smp();
        chk1("lw_t2_req",   bus_if.data_req_o, 1'b0);
        chk1("lw_t2_stall", stall_o, 1'b1);
        chk1("lw_t2_done",  done_o, 1'b0);
        nxt();
        bus_if.data_data_ok_i = 1'b1;
        bus_if.data_rdata_i   = 32'hDEAD_BEEF;
        smp();
        chk1 ("lw_t3_done",  done_o, 1'b1);
        chk32("lw_t3_rdata", rdata_o, 32'hDEAD_BEEF);
        chk1 ("lw_t3_stall", stall_o, 1'b0);
        nxt();
        idle_inputs();

        // LL flushed in DATA, drain, then a LW presented during the drain
        drive_op(LL, 32'h0000_0300, 32'h0, 1'b0);
        smp();
        chk1("fl_t0_stall", stall_o, 1'b1);
        nxt();
        bus_if.data_addr_ok_i = 1'b1;
        smp();
        chk1("fl_t1_req", bus_if.data_req_o, 1'b1);
        nxt();
        bus_if.data_addr_ok_i = 1'b0;
        flush = 1'b1;
        smp();
        chk1("fl_t2_stall", stall_o, 1'b0);
        chk1("fl_t2_done",  done_o, 1'b0);
        chk1("fl_t2_llwe",  LLbit_we_o, 1'b0);
        nxt();
        flush = 1'b0;
        drive_op(LW, 32'h0000_0400, 32'h0, 1'b0);
        smp();
        chk1("dr_t3_req",   bus_if.data_req_o, 1'b0);
        chk1("dr_t3_stall", stall_o, 1'b1);
        chk1("dr_t3_done",  done_o, 1'b0);
        nxt();
        bus_if.data_data_ok_i = 1'b1;
        bus_if.data_rdata_i   = 32'h7777_7777;
        smp();
        chk1("dr_t4_done",  done_o, 1'b0);
        chk1("dr_t4_llwe",  LLbit_we_o, 1'b0);
        chk1("dr_t4_req",   bus_if.data_req_o, 1'b0);
        chk1("dr_t4_stall", stall_o, 1'b1);
        nxt();
        bus_if.data_data_ok_i = 1'b0;
        smp();
        chk1("dr_t5_req",   bus_if.data_req_o, 1'b0);
        chk1("dr_t5_stall", stall_o, 1'b1);
        chk1("dr_t5_done",  done_o, 1'b0);
        nxt();
        bus_if.data_addr_ok_i = 1'b1;
        bus_if.data_data_ok_i = 1'b1;
        bus_if.data_rdata_i   = 32'h1357_2468;
        smp();
        chk1 ("dr_t6_req",   bus_if.data_req_o, 1'b1);
        chk32("dr_t6_addr",  bus_if.data_addr_o, 32'h0000_0400);
        chk1 ("dr_t6_done",  done_o, 1'b1);
        chk32("dr_t6_rdata", rdata_o, 32'h1357_2468);
        nxt();
        idle_inputs();

        // SW waiting for addr_ok, then flushed in ADDR: request withdrawn
        drive_op(SW, 32'h0000_0500, 32'hA5A5_A5A5, 1'b0);
        smp();
        chk1("fa_t0_stall", stall_o, 1'b1);
        nxt();
        smp();
        chk1("fa_t1_req",   bus_if.data_req_o, 1'b1);
        chk1("fa_t1_stall", stall_o, 1'b1);
        nxt();
        smp();
        chk1 ("fa_t2_req",   bus_if.data_req_o, 1'b1);
        chk32("fa_t2_wdata", bus_if.data_wdata_o, 32'hA5A5_A5A5);
        nxt();
        flush = 1'b1;
        smp();
        chk1("fa_t3_stall", stall_o, 1'b0);
        chk1("fa_t3_done",  done_o, 1'b0);
        nxt();
        idle_inputs();
        smp();
        chk1("fa_t4_req",   bus_if.data_req_o, 1'b0);
        chk1("fa_t4_stall", stall_o, 1'b0);
        nxt();

        // Reset mid-transfer abandons the request
        drive_op(LW, 32'h0000_0600, 32'h0, 1'b0);
        nxt();
        idle_inputs();
        rst = 1'b1;
        smp();
        chk1("rm_req_before", bus_if.data_req_o, 1'b1);
        nxt();
        rst = 1'b0;
        smp();
        chk1 ("rm_req",   bus_if.data_req_o, 1'b0);
        chk32("rm_addr",  bus_if.data_addr_o, 32'd0);
        chk1 ("rm_stall", stall_o, 1'b0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
